// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared definitions for the digit-serial adder.
//   - state_e   : FSM state encoding (IDLE, RUN, DONE)
//   - DEF_WIDTH : default operand/result width
//   - DEF_DIGIT : default number of bits added per cycle
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 1;

endpackage

// File: rtl/serial_add_carryAhead1b.sv
// carryAhead1b: 1-bit full adder in generate/propagate form.
//   A, B  : addend bits
//   C     : carry in
//   S     : sum bit
//   Cout  : carry out
module carryAhead1b (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic S,
  output logic Cout
);

  logic g_s;
  logic p_s;

  assign g_s  = A & B;
  assign p_s  = A ^ B;
  assign S    = p_s ^ C;
  assign Cout = g_s | (p_s & C);

endmodule

// File: rtl/serial_add.sv
// serial_add: digit-serial two's-complement adder, DIGIT bits per cycle over
// WIDTH/DIGIT cycles, valid/ready handshake on operand and result sides.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   A, B, Cin           : augend, addend, carry-in
//   out_valid/out_ready : result handshake (valid only in DONE)
//   result, Cout        : A + B + Cin mod 2^WIDTH and carry out of MSB
//   overflow            : signed overflow (carry into MSB xor carry out)
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             Cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Carry chain: chain_c[i] is the carry into bit i of the current digit.
  logic [DIGIT:0]   chain_c;
  logic [DIGIT-1:0] sum_s;

  assign chain_c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    carryAhead1b u_fa (
      .A    (a_q[i]),
      .B    (b_q[i]),
      .C    (chain_c[i]),
      .S    (sum_s[i]),
      .Cout (chain_c[i+1])
    );
  end

  // Next-state, datapath shift and output-latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New sum digit enters at the MSB end so after N steps the first
        // digit has reached bit 0.
        res_d   = (res_q >> DIGIT) | (WIDTH'(sum_s) << (WIDTH - DIGIT));
        carry_d = chain_c[DIGIT];
        if (cnt_q == CNT_LAST) begin
          cout_d  = chain_c[DIGIT];
          ovf_d   = chain_c[DIGIT] ^ chain_c[DIGIT-1];
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign Cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/serial_add.md
# serial_add

Digit-serial two's-complement adder with valid/ready handshakes on both sides. It is the addition counterpart to the ALU's 32-bit ripple-borrow subtract operation. It trades latency for area by reusing one DIGIT-bit carry chain over WIDTH/DIGIT cycles. It sits in the ALU operations group, is selected by the ALU op decoder, and returns sum, carry-out and signed overflow.

## Interface
- WIDTH, 32: operand and result width in bits.
- DIGIT, 1: bits processed per cycle. Must divide WIDTH. N = WIDTH/DIGIT.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- A  input  WIDTH  augend.
- B  input  WIDTH  addend.
- Cin  input  1  carry-in.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  A + B + Cin, modulo 2^WIDTH.
- Cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into MSB XOR Cout.

## Operation
- Uses three states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, load the A and B shift registers, set carry=Cin, clear the digit counter, and go to RUN.
- RUN: each edge adds the low DIGIT bits of A and B plus carry through the carry chain.
  - The sum digit is shifted into result from the MSB end. A and B shift right by DIGIT. The counter increments.
  - On the edge where counter==N-1, latch Cout and overflow and go to DONE.
- The overflow source is the carry into bit DIGIT-1 of the final digit, taken from inside the chain. For DIGIT=1 this is the carry register before the last step.
- DONE: out_valid=1. result, Cout and overflow are held stable. On out_valid&&out_ready, go to IDLE.
- Inputs A, B, Cin and in_valid are ignored outside IDLE. out_ready is ignored outside DONE.
- There is no accept in the same cycle as a result handshake, so in_ready and out_valid are never both high.
- result, Cout and overflow are registered outputs. They keep the last values until the next operation begins writing result.

## Timing
- Reset (rst_n low at an edge, in any state, including mid-RUN):
  - Next state is IDLE; the operation in flight is discarded.
  - Outputs after that edge: in_ready=1, out_valid=0, result=0, Cout=0, overflow=0.
  - Counter, carry and shift registers are cleared.
- Latency: accept at edge t0 gives out_valid high after edge t0+N.
  - WIDTH=32, DIGIT=1: 32 cycles.
  - WIDTH=32, DIGIT=4: 8 cycles.
- Result handshake at edge t1 gives in_ready high after t1. The next accept is possible at edge t1+1.
  - Minimum initiation interval is N+2 cycles.
- Backpressure: DONE holds indefinitely with outputs unchanged.
- Counter width is clog2(N) and it never wraps. The RUN→DONE transition occurs exactly at N-1.
- Arithmetic wraps modulo 2^WIDTH. All-ones plus 1 gives 0 with Cout=1.

## Structure
- Shared ALU package/header holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH and DIGIT values.
- Sub-module carryAhead1b: 1-bit full adder.
  - Ports: A, B, C in; S sum; Cout.
  - Generate/propagate form.
- serial_add instantiates DIGIT copies of carryAhead1b chained by carry; the chain is the only combinational datapath.
- FSM, counter and shift registers live in serial_add.

## Test plan
- A=0x00000005, B=0x00000003, Cin=0, DIGIT=1 -> result=0x00000008, Cout=0, overflow=0; out_valid rises exactly 32 cycles after the accept edge.
- A=0xFFFFFFFF, B=0x00000001, Cin=0 -> result=0x00000000, Cout=1, overflow=0.
- A=0x7FFFFFFF, B=0x00000001, Cin=0 -> result=0x80000000, Cout=0, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result, Cout and overflow stay stable, in_ready=0, and in_valid pulses are ignored. Assert out_ready -> in_ready=1 on the next cycle.
- Reset mid-operation: drop rst_n at RUN cycle 16 -> all outputs at reset values after that edge. Then A=0x12345678, B=0x11111111, Cin=1 -> result=0x2345678A, Cout=0, overflow=0.
- DIGIT=4 instance: A=0x80000000, B=0x80000000, Cin=0 -> result=0x00000000, Cout=1, overflow=1, latency 8 cycles.
